wb_x1_bridge: RTL and testbench

- Registered Wishbone decode/bridge stage between the Caravel management Wishbone master and the two Neuromorphic_X1_wb slaves in the user project wrapper.
- Decodes two 4 KB windows. Allows exactly one outstanding transaction.
- Drives registered request signals to the selected slave and returns its response to the master.
- Terminates unmapped accesses and hung slaves itself with a watchdog timeout and an error pulse.

---
 rtl/wb_x1_bridge_if.sv | 22 ++
 rtl/wb_x1_bridge.sv | 166 ++++++++++++++++
 tb/tb_wb_x1_bridge.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_x1_bridge_if.sv
// rtl/wb_x1_bridge_if.sv - Caravel management Wishbone port bundle for wb_x1_bridge
interface wb_x1_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  // The bridge sits on this bus as a slave of the management core.
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_x1_bridge.sv
// rtl/wb_x1_bridge.sv - registered Wishbone decode stage for two Neuromorphic_X1 slaves (option: WB_X1_BRIDGE_STATUS_EN)
module wb_x1_bridge #(
  parameter logic [31:0] S0_BASE        = 32'h0000_0000,
  parameter logic [31:0] S1_BASE        = 32'h0000_1000,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] UNMAPPED_DATA  = 32'hBADA_DD00,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_x1_bridge_if.slave        wbs,
  output logic [31:0]          s_adr_o,
  output logic [31:0]          s_dat_o,
  output logic [3:0]           s_sel_o,
  output logic                 s_we_o,
  output logic                 s0_cyc_o,
  output logic                 s0_stb_o,
  output logic                 s1_cyc_o,
  output logic                 s1_stb_o,
  input  logic                 s0_ack_i,
  input  logic                 s1_ack_i,
  input  logic [31:0]          s0_dat_i,
  input  logic [31:0]          s1_dat_i,
  output logic                 err_pulse_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [19:0] S0_PAGE = S0_BASE[31:12];
  localparam logic [19:0] S1_PAGE = S1_BASE[31:12];
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [31:0] s_adr_q, s_dat_q, resp_q;
  logic [3:0]  s_sel_q;
  logic        s_we_q, s0_en_q, s1_en_q, ack_q, err_q;
  logic        slv_q;          // 0: slave 0 owns the transfer, 1: slave 1
  logic [15:0] wdog_q, wdog_d;

  logic        req, hit_s0, hit_s1, sel_ack;
  logic [31:0] sel_dat;

  assign req     = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  // Slave 0 wins if both windows are configured onto the same page.
  assign hit_s0  = (wbs.wbs_adr_i[31:12] == S0_PAGE);
  assign hit_s1  = !hit_s0 && (wbs.wbs_adr_i[31:12] == S1_PAGE);
  assign sel_ack = slv_q ? s1_ack_i : s0_ack_i;
  assign sel_dat = slv_q ? s1_dat_i : s0_dat_i;
  assign wdog_d  = wdog_q + 16'd1;

`ifdef WB_X1_BRIDGE_STATUS_EN
  logic        hit_st;
  logic [15:0] tmo_cnt_q;
  logic        tmo_flag_q;
  assign hit_st = !hit_s0 && !hit_s1 && (wbs.wbs_adr_i[31:12] == 20'h00002);
`endif

  // Single FSM; every output is a flop so slaves see clean registered requests.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      s_adr_q    <= '0;
      s_dat_q    <= '0;
      s_sel_q    <= '0;
      s_we_q     <= 1'b0;
      s0_en_q    <= 1'b0;
      s1_en_q    <= 1'b0;
      slv_q      <= 1'b0;
      ack_q      <= 1'b0;
      resp_q     <= '0;
      err_q      <= 1'b0;
      wdog_q     <= '0;
`ifdef WB_X1_BRIDGE_STATUS_EN
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            s_adr_q <= wbs.wbs_adr_i;
            s_dat_q <= wbs.wbs_dat_i;
            s_sel_q <= wbs.wbs_sel_i;
            s_we_q  <= wbs.wbs_we_i;
            if (hit_s0 || hit_s1) begin
              s0_en_q <= hit_s0;
              s1_en_q <= hit_s1;
              slv_q   <= hit_s1;
              wdog_q  <= '0;
              state_q <= BUSY;
            end
`ifdef WB_X1_BRIDGE_STATUS_EN
            else if (hit_st) begin
              if (wbs.wbs_we_i) begin
                resp_q <= '0;
                if (wbs.wbs_dat_i[0] && wbs.wbs_sel_i[0]) begin
                  tmo_cnt_q  <= '0;
                  tmo_flag_q <= 1'b0;
                end
              end else begin
                resp_q <= {tmo_cnt_q, 15'b0, tmo_flag_q};
              end
              ack_q   <= 1'b1;
              state_q <= RESP;
            end
`endif
            else begin
              // Nothing lives here: answer locally, drop any write.
              resp_q  <= wbs.wbs_we_i ? 32'd0 : UNMAPPED_DATA;
              ack_q   <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        BUSY: begin
          if (!wbs.wbs_cyc_i) begin
            // Master gave up; release the slave silently.
            s0_en_q <= 1'b0;
            s1_en_q <= 1'b0;
            state_q <= IDLE;
          end else if (sel_ack) begin
            // Checked before the watchdog so an ack on the last cycle wins.
            s0_en_q <= 1'b0;
            s1_en_q <= 1'b0;
            resp_q  <= s_we_q ? 32'd0 : sel_dat;
            ack_q   <= 1'b1;
            state_q <= RESP;
          end else if (wdog_q == LAST_CNT) begin
            s0_en_q <= 1'b0;
            s1_en_q <= 1'b0;
            resp_q  <= s_we_q ? 32'd0 : TIMEOUT_DATA;
            err_q   <= 1'b1;
            ack_q   <= 1'b1;
            state_q <= RESP;
`ifdef WB_X1_BRIDGE_STATUS_EN
            tmo_flag_q <= 1'b1;
            if (tmo_cnt_q != 16'hFFFF) tmo_cnt_q <= tmo_cnt_q + 16'd1;
`endif
          end else begin
            wdog_q <= wdog_d;
          end
        end
        RESP: begin
          ack_q   <= 1'b0;
          resp_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = resp_q;
  assign s_adr_o       = s_adr_q;
  assign s_dat_o       = s_dat_q;
  assign s_sel_o       = s_sel_q;
  assign s_we_o        = s_we_q;
  assign s0_cyc_o      = s0_en_q;
  assign s0_stb_o      = s0_en_q;
  assign s1_cyc_o      = s1_en_q;
  assign s1_stb_o      = s1_en_q;
  assign err_pulse_o   = err_q;

endmodule

// File: tb/tb_wb_x1_bridge.sv
// tb/tb_wb_x1_bridge.sv - directed self-checking bench for wb_x1_bridge
module tb_wb_x1_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_adr, s_dat, s0_dat, s1_dat;
  logic [3:0]  s_sel;
  logic        s_we, s0_cyc, s0_stb, s1_cyc, s1_stb, s0_ack, s1_ack, err;
  logic        s0_force = 1'b0, s1_force = 1'b0;
  int          s0_lat = 0, s1_lat = 0, s0_run = 0, s1_run = 0;
  int          s0_hi = 0, s1_hi = 0, acks = 0, errs = 0, cyc_mis = 0;
  int          n_checks = 0, n_err = 0;

  always #5 clk = ~clk;

  wb_x1_bridge_if bus ();

  wb_x1_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus),
    .s_adr_o(s_adr), .s_dat_o(s_dat), .s_sel_o(s_sel), .s_we_o(s_we),
    .s0_cyc_o(s0_cyc), .s0_stb_o(s0_stb), .s1_cyc_o(s1_cyc), .s1_stb_o(s1_stb),
    .s0_ack_i(s0_ack), .s1_ack_i(s1_ack), .s0_dat_i(s0_dat), .s1_dat_i(s1_dat),
    .err_pulse_o(err)
  );

  // Slave models: ack once stb has been high for *_lat cycles (0 = never).
  always @(posedge clk) begin
    s0_run <= s0_stb ? s0_run + 1 : 0;
    s1_run <= s1_stb ? s1_run + 1 : 0;
  end
  assign s0_ack = s0_force | (s0_stb && s0_lat != 0 && s0_run == s0_lat - 1);
  assign s1_ack = s1_force | (s1_stb && s1_lat != 0 && s1_run == s1_lat - 1);

  // Running activity totals, sampled mid-cycle.
  always @(negedge clk) begin
    if (s0_stb) s0_hi <= s0_hi + 1;
    if (s1_stb) s1_hi <= s1_hi + 1;
    if (bus.wbs_ack_o) acks <= acks + 1;
    if (err) errs <= errs + 1;
    if ((s0_cyc !== s0_stb) || (s1_cyc !== s1_stb)) cyc_mis <= cyc_mis + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
  endtask

  // One master transfer; lat = cycle index of the master ack (request cycle = 0).
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd, output int lat);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    lat = -1;
    rd  = 32'hx;
    for (int i = 1; i <= 200 && lat < 0; i++) begin
      tick();
      if (bus.wbs_ack_o) begin
        lat = i;
        rd  = bus.wbs_dat_o;
      end
    end
    idle_bus();
    check("xfer_acked", 32'(lat > 0), 32'd1);
    tick();
  endtask

  logic [31:0] rd;
  int lat, h0, h1, a0, e0;

  task automatic snap();
    h0 = s0_hi; h1 = s1_hi; a0 = acks; e0 = errs;
  endtask

  initial begin
    idle_bus();
    s0_dat = 32'h0; s1_dat = 32'h0;
    rst = 1'b1;
    tick(); tick(); tick();
    check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
    check("rst_dat", bus.wbs_dat_o, 32'd0);
    check("rst_sadr", s_adr, 32'd0);
    check("rst_stb", 32'({s0_cyc, s0_stb, s1_cyc, s1_stb, err, s_we}), 32'd0);
    rst = 1'b0;
    tick();

    // Slave 0 read, ack after 2 stb cycles; slave 1 acks spuriously throughout.
    s0_lat = 2; s0_dat = 32'h1234_5678; s1_dat = 32'h5555_AAAA; s1_force = 1'b1;
    snap();
    xfer(1'b0, 32'h0000_0010, 32'h0, 4'hF, rd, lat);
    s1_force = 1'b0;
    check("s0rd_data", rd, 32'h1234_5678);
    check("s0rd_lat", 32'(lat), 32'd3);
    check("s0rd_s0hi", 32'(s0_hi - h0), 32'd2);
    check("s0rd_s1hi", 32'(s1_hi - h1), 32'd0);
    check("s0rd_acks", 32'(acks - a0), 32'd1);
    check("s0rd_adr", s_adr, 32'h0000_0010);

    // Slave 1 write: response data must be zero even though slave drives data.
    s1_lat = 1; s1_dat = 32'hFFFF_FFFF;
    snap();
    xfer(1'b1, 32'h0000_1004, 32'hA5A5_0001, 4'b0011, rd, lat);
    check("s1wr_data", rd, 32'h0);
    check("s1wr_lat", 32'(lat), 32'd2);
    check("s1wr_s1hi", 32'(s1_hi - h1), 32'd1);
    check("s1wr_s0hi", 32'(s0_hi - h0), 32'd0);
    check("s1wr_adr", s_adr, 32'h0000_1004);
    check("s1wr_sel", 32'(s_sel), 32'd3);
    check("s1wr_dat", s_dat, 32'hA5A5_0001);
    check("s1wr_we", 32'(s_we), 32'd1);

    // Unmapped read and write.
    snap();
    xfer(1'b0, 32'h0000_3000, 32'h0, 4'hF, rd, lat);
    check("unm_rd_data", rd, 32'hBADA_DD00);
    check("unm_rd_lat", 32'(lat), 32'd1);
    xfer(1'b1, 32'h0000_3000, 32'h1111_1111, 4'hF, rd, lat);
    check("unm_wr_data", rd, 32'h0);
    check("unm_wr_lat", 32'(lat), 32'd1);
    check("unm_stb", 32'((s0_hi - h0) + (s1_hi - h1)), 32'd0);

    // Timeout on slave 0.
    s0_lat = 0;
    snap();
    xfer(1'b0, 32'h0000_0000, 32'h0, 4'hF, rd, lat);
    check("tmo_data", rd, 32'hDEAD_BEEF);
    check("tmo_lat", 32'(lat), 32'd9);
    check("tmo_s0hi", 32'(s0_hi - h0), 32'd8);
    check("tmo_err", 32'(errs - e0), 32'd1);

`ifdef WB_X1_BRIDGE_STATUS_EN
    xfer(1'b0, 32'h0000_2000, 32'h0, 4'hF, rd, lat);
    check("st_rd", rd, 32'h0001_0001);
    check("st_lat", 32'(lat), 32'd1);
    xfer(1'b1, 32'h0000_2000, 32'h0000_0001, 4'h1, rd, lat);
    xfer(1'b0, 32'h0000_2000, 32'h0, 4'hF, rd, lat);
    check("st_clr", rd, 32'h0);
`else
    xfer(1'b0, 32'h0000_2000, 32'h0, 4'hF, rd, lat);
    check("st_unmapped", rd, 32'hBADA_DD00);
`endif

    // Ack lands in the expiry cycle: slave data wins, no error.
    s0_lat = 8; s0_dat = 32'hCAFE_F00D;
    snap();
    xfer(1'b0, 32'h0000_0004, 32'h0, 4'hF, rd, lat);
    check("exp_data", rd, 32'hCAFE_F00D);
    check("exp_lat", 32'(lat), 32'd9);
    check("exp_err", 32'(errs - e0), 32'd0);
    check("exp_s0hi", 32'(s0_hi - h0), 32'd8);

    // Acks while idle are ignored.
    snap();
    s0_force = 1'b1; s1_force = 1'b1;
    tick(); tick();
    s0_force = 1'b0; s1_force = 1'b0;
    tick();
    check("idle_ack", 32'(acks - a0), 32'd0);

    // Master abort 3 cycles into BUSY, then a late slave ack.
    s0_lat = 0;
    snap();
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = 32'h0000_0008; bus.wbs_sel_i = 4'hF;
    tick(); tick(); tick();
    idle_bus();
    tick();
    check("abort_stb", 32'({s0_cyc, s0_stb}), 32'd0);
    s0_force = 1'b1;
    tick();
    s0_force = 1'b0;
    tick(); tick();
    check("abort_acks", 32'(acks - a0), 32'd0);
    check("abort_s0hi", 32'(s0_hi - h0), 32'd3);

    // Back in IDLE: a normal transfer works.
    s0_lat = 1; s0_dat = 32'h0BAD_F00D;
    xfer(1'b0, 32'h0000_0020, 32'h0, 4'hF, rd, lat);
    check("post_abort_data", rd, 32'h0BAD_F00D);
    check("post_abort_lat", 32'(lat), 32'd2);

    // Reset in the middle of a slave 1 transfer.
    s1_lat = 0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = 32'h0000_1008; bus.wbs_dat_i = 32'h7777_7777; bus.wbs_sel_i = 4'hF;
    tick(); tick(); tick();
    check("pre_rst_busy", 32'(s1_stb), 32'd1);
    rst = 1'b1;
    idle_bus();
    tick();
    check("mid_rst_ctl", 32'({s0_cyc, s0_stb, s1_cyc, s1_stb, err, s_we, bus.wbs_ack_o}), 32'd0);
    check("mid_rst_adr", s_adr, 32'd0);
    check("mid_rst_dat", s_dat, 32'd0);
    check("mid_rst_sel", 32'(s_sel), 32'd0);
    check("mid_rst_rdat", bus.wbs_dat_o, 32'd0);
    rst = 1'b0;
    tick(); tick();

    check("cyc_eq_stb", 32'(cyc_mis), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
